arm_decode_stage: RTL and testbench



---
 rtl/arm_decode_stage.sv | 132 +++++++++++++
 tb/tb_arm_decode_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/arm_decode_stage.sv
// arm_decode_stage: ID-stage control block for the five-stage ARM pipeline.
//   Holds the fetch-path PC+4 adder, the instruction decoder and the hazard
//   bubble mux. The muxed controls also feed a one-stage ID/EX control
//   register.
// Optional feature macro: CU_NOP_DETECT_EN. When it is defined, instruction
//   0x00000000 decodes as a NOP with every control low. When it is not
//   defined, that word decodes as ANDEQ r0,r0,r0.
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   pc_current        current PC
//   pc_plus_4         combinational pc_current + 4 (wraps mod 2^32)
//   instruction       instruction word from the IF/ID register
//   hazard_select     1 forces a bubble (all id_* controls low)
//   id_*              combinational muxed controls for the ID stage
//   ex_*              registered ID/EX copies (pc_src is consumed in ID, not registered)
module arm_decode_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_current,
   output logic [31:0] pc_plus_4,
   input  logic [31:0] instruction,
   input  logic        hazard_select,
   output logic        id_reg_write,
   output logic        id_mem_write,
   output logic        id_mem_to_reg,
   output logic        id_alu_src,
   output logic        id_status_bit,
   output logic        id_pc_src,
   output logic        id_mem_byte,
   output logic [3:0]  id_alu_op,
   output logic        ex_reg_write,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        ex_alu_src,
   output logic        ex_status_bit,
   output logic        ex_mem_byte,
   output logic [3:0]  ex_alu_op
);

   localparam int unsigned ALU_OP_W = 4;
   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0100);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0010);

   typedef struct packed {
      logic                reg_write;
      logic                mem_write;
      logic                mem_to_reg;
      logic                alu_src;
      logic                status_bit;
      logic                pc_src;
      logic                mem_byte;
      logic [ALU_OP_W-1:0] alu_op;
   } ctrl_t;

   ctrl_t dec;
   ctrl_t muxed;

   // The condition field and the register/offset fields are not decoded in this block.
   logic unused_fields;
   assign unused_fields = ^{instruction[31:28], instruction[19:0]};

   // Fetch-path adder; a carry out of bit 31 is dropped.
   assign pc_plus_4 = pc_current + 32'd4;

   // Control unit: the decode class is chosen by instruction[27:25].
   always_comb begin
      dec = '0;
      unique casez (instruction[27:25])
         3'b00?: begin
            dec.alu_op     = instruction[24:21];
            dec.status_bit = instruction[20];
            dec.alu_src    = instruction[25];
            // TST/TEQ/CMP/CMN only set flags; they write no register.
            dec.reg_write  = (instruction[24:23] != 2'b10);
         end
         3'b01?: begin
            dec.alu_src    = ~instruction[25];
            dec.alu_op     = instruction[23] ? ALU_ADD : ALU_SUB;
            dec.mem_byte   = instruction[22];
            dec.reg_write  = instruction[20];
            dec.mem_to_reg = instruction[20];
            dec.mem_write  = ~instruction[20];
         end
         3'b101: begin
            dec.pc_src     = 1'b1;
            dec.reg_write  = instruction[24];
            dec.alu_op     = ALU_ADD;
            dec.alu_src    = 1'b1;
         end
         default: dec = '0;
      endcase
`ifdef CU_NOP_DETECT_EN
      if (instruction == 32'h0000_0000) begin
         dec = '0;
      end
`endif
   end

   // Bubble mux.
   assign muxed = hazard_select ? ctrl_t'('0) : dec;

   assign id_reg_write  = muxed.reg_write;
   assign id_mem_write  = muxed.mem_write;
   assign id_mem_to_reg = muxed.mem_to_reg;
   assign id_alu_src    = muxed.alu_src;
   assign id_status_bit = muxed.status_bit;
   assign id_pc_src     = muxed.pc_src;
   assign id_mem_byte   = muxed.mem_byte;
   assign id_alu_op     = muxed.alu_op;

   // ID/EX control register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_reg_write  <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_status_bit <= 1'b0;
         ex_mem_byte   <= 1'b0;
         ex_alu_op     <= '0;
      end else begin
         ex_reg_write  <= muxed.reg_write;
         ex_mem_write  <= muxed.mem_write;
         ex_mem_to_reg <= muxed.mem_to_reg;
         ex_alu_src    <= muxed.alu_src;
         ex_status_bit <= muxed.status_bit;
         ex_mem_byte   <= muxed.mem_byte;
         ex_alu_op     <= muxed.alu_op;
      end
   end

endmodule

// File: tb/tb_arm_decode_stage.sv
// tb_arm_decode_stage: directed-vector bench for arm_decode_stage.
//   Control words are compared as {reg_write, mem_write, mem_to_reg, alu_src,
//   status_bit, pc_src, mem_byte, alu_op}. The ID/EX word is the same set
//   without pc_src.
module tb_arm_decode_stage;

   logic        clk;
   logic        reset;
   logic [31:0] pc_current;
   logic [31:0] pc_plus_4;
   logic [31:0] instruction;
   logic        hazard_select;
   logic        id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src;
   logic        id_status_bit, id_pc_src, id_mem_byte;
   logic [3:0]  id_alu_op;
   logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_src;
   logic        ex_status_bit, ex_mem_byte;
   logic [3:0]  ex_alu_op;

   int unsigned n_compared = 0;
   int unsigned n_mismatched = 0;

   arm_decode_stage dut (
      .clk           (clk),
      .reset         (reset),
      .pc_current    (pc_current),
      .pc_plus_4     (pc_plus_4),
      .instruction   (instruction),
      .hazard_select (hazard_select),
      .id_reg_write  (id_reg_write),
      .id_mem_write  (id_mem_write),
      .id_mem_to_reg (id_mem_to_reg),
      .id_alu_src    (id_alu_src),
      .id_status_bit (id_status_bit),
      .id_pc_src     (id_pc_src),
      .id_mem_byte   (id_mem_byte),
      .id_alu_op     (id_alu_op),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_write  (ex_mem_write),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_alu_src    (ex_alu_src),
      .ex_status_bit (ex_status_bit),
      .ex_mem_byte   (ex_mem_byte),
      .ex_alu_op     (ex_alu_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [10:0] id_word;
   logic [9:0]  ex_word;
   assign id_word = {id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src,
                     id_status_bit, id_pc_src, id_mem_byte, id_alu_op};
   assign ex_word = {ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                     ex_status_bit, ex_mem_byte, ex_alu_op};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected ID/EX word derived from an expected ID word (drop pc_src).
   function automatic logic [9:0] ex_of(input logic [10:0] e);
      return {e[10:6], e[4:0]};
   endfunction

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [10:0] exp;
   } vec_t;

   localparam logic [10:0] EXP_ADD = {7'b1000000, 4'b0100};
`ifdef CU_NOP_DETECT_EN
   localparam logic [10:0] EXP_NOP = 11'b0;
`else
   localparam logic [10:0] EXP_NOP = {7'b1000000, 4'b0000};
`endif

   vec_t vecs[$];

   initial begin
      vecs.push_back('{"ands",  32'hE2110000, {7'b1001100, 4'b0000}});
      vecs.push_back('{"add",   32'hE0805183, EXP_ADD});
      vecs.push_back('{"ldrb",  32'hE7D12000, {7'b1010001, 4'b0100}});
      vecs.push_back('{"str",   32'hE58A5000, {7'b0101000, 4'b0100}});
      vecs.push_back('{"strb_d",32'hE5411001, {7'b0101001, 4'b0010}});
      vecs.push_back('{"bne",   32'h1AFFFFFD, {7'b0001010, 4'b0100}});
      vecs.push_back('{"blle",  32'hDB000009, {7'b1001010, 4'b0100}});
      vecs.push_back('{"cmp",   32'hE1500001, {7'b0000100, 4'b1010}});
      vecs.push_back('{"ldm",   32'hE8BD0003, 11'b0});
      vecs.push_back('{"nop",   32'h00000000, EXP_NOP});

      reset         = 1'b0;
      pc_current    = 32'h0;
      instruction   = 32'hE0805183;
      hazard_select = 1'b0;

      // Reset state, and combinational paths alive during reset.
      #2;
      check("rst_ex", 32'(ex_word), 32'h0);
      check("rst_id_comb", 32'(id_word), 32'(EXP_ADD));
      check("add_pc0", pc_plus_4, 32'h4);
      @(posedge clk); #1;
      check("rst_hold_ex", 32'(ex_word), 32'h0);

      pc_current = 32'hFFFFFFFC; #1;
      check("add_wrap", pc_plus_4, 32'h0);
      pc_current = 32'h0000_1000; #1;
      check("add_mid", pc_plus_4, 32'h0000_1004);

      @(negedge clk);
      reset = 1'b1;

      // Directed decode vectors: ID combinationally, EX one edge later.
      foreach (vecs[i]) begin
         @(negedge clk);
         instruction = vecs[i].instr;
         #1;
         check({"id_", vecs[i].name}, 32'(id_word), 32'(vecs[i].exp));
         @(posedge clk); #1;
         check({"ex_", vecs[i].name}, 32'(ex_word), 32'(ex_of(vecs[i].exp)));
      end

      // Bubble with ADD applied.
      @(negedge clk);
      instruction   = 32'hE0805183;
      hazard_select = 1'b1;
      #1;
      check("bubble_id", 32'(id_word), 32'h0);
      @(posedge clk); #1;
      check("bubble_ex", 32'(ex_word), 32'h0);

      // hazard_select raised mid-cycle, dropped before the edge: ADD is captured.
      @(negedge clk);
      hazard_select = 1'b0;
      #2 hazard_select = 1'b1;
      #1 hazard_select = 1'b0;
      @(posedge clk); #1;
      check("hz_edge_ex", 32'(ex_word), 32'(ex_of(EXP_ADD)));

      // Reset asserted mid-cycle clears ex_* immediately and holds them.
      #2 reset = 1'b0;
      #1;
      check("async_rst_ex", 32'(ex_word), 32'h0);
      check("async_rst_id", 32'(id_word), 32'(EXP_ADD));
      @(posedge clk); #1;
      check("rst_hold2_ex", 32'(ex_word), 32'h0);

      // First capture after release.
      @(negedge clk);
      reset = 1'b1;
      instruction = 32'hE7D12000;
      @(posedge clk); #1;
      check("post_rst_ex", 32'(ex_word), 32'(ex_of({7'b1010001, 4'b0100})));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
